rule_sched: RTL and testbench

RULE_SCHED -- requirements
Module: rule_sched

---
 rtl/fuzzy_pkg.sv | 30 +++
 rtl/seq_div.sv | 73 +++++++
 rtl/rule_sched.sv | 151 +++++++++++++++
 tb/tb_rule_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// Shared types and widths for the two-input fuzzy rule scheduler.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package fuzzy_pkg;

  localparam int MU_W     = 16;  // membership width
  localparam int NUM_W    = 35;  // signed weighted-sum accumulator
  localparam int DEN_W    = 18;  // unsigned weight-sum accumulator
  localparam int MAG_W    = 34;  // magnitude of the numerator
  localparam int DIV_ITER = 34;  // one quotient bit per iteration

  typedef enum logic [1:0] {IDLE, EVAL, DIV, DONE} state_e;
  typedef enum logic [1:0] {NN, NP, PN, PP} rule_e;

  typedef struct packed {
    logic [MU_W-1:0] t_neg;
    logic [MU_W-1:0] t_pos;
    logic [MU_W-1:0] d_neg;
    logic [MU_W-1:0] d_pos;
  } mu_t;

  // Reapply the sign to a truncated quotient magnitude and clamp to int16.
  function automatic logic [15:0] sat_s16(input logic neg, input logic [MAG_W-1:0] mag);
    logic [15:0] lo;
    lo = mag[15:0];
    if (!neg) return (mag > MAG_W'(32767)) ? 16'h7FFF : lo;
    return (mag > MAG_W'(32768)) ? 16'h8000 : 16'(-lo);
  endfunction

endpackage

// File: rtl/seq_div.sv
// Restoring unsigned divider, 34-bit dividend / 18-bit divisor, one quotient bit per cycle.
// Latency: start edge performs iteration 1; done rises with the 34th iteration (33 edges later).
// Backpressure: none; divisor must stay stable until done, quotient holds until next start.
module seq_div
  import fuzzy_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MAG_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             done,
  output logic [MAG_W-1:0] quot
);

  logic [DEN_W-1:0] rem_q, rem_d;
  logic [MAG_W-1:0] quo_q, quo_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [DEN_W-1:0] src_rem, it_rem;
  logic [MAG_W-1:0] src_quo, it_quo;
  logic [DEN_W:0]   sh;

  // One restoring step; a start folds the operand load into the first step.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    sh      = {src_rem, src_quo[MAG_W-1]};
    if (sh >= {1'b0, divisor}) begin
      it_rem = DEN_W'(sh - {1'b0, divisor});
      it_quo = {src_quo[MAG_W-2:0], 1'b1};
    end else begin
      it_rem = sh[DEN_W-1:0];
      it_quo = {src_quo[MAG_W-2:0], 1'b0};
    end

    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (start) begin
      rem_d  = it_rem;
      quo_d  = it_quo;
      cnt_d  = 6'(DIV_ITER - 1);
      done_d = 1'b0;
    end else if (cnt_q != 6'd0) begin
      rem_d  = it_rem;
      quo_d  = it_quo;
      cnt_d  = cnt_q - 6'd1;
      done_d = (cnt_q == 6'd1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign quot = quo_q;

endmodule

// File: rtl/rule_sched.sv
// Four-rule fuzzy inference with weighted-average defuzzification on shared min/mul/div.
// Latency: result valid 39 edges after acceptance (6 edges when every rule weight is zero).
// Backpressure: accepts only in IDLE; DONE holds the result until out_ready.
module rule_sched
  import fuzzy_pkg::*;
#(
  parameter logic signed [15:0] S_NN = -16'sd1000,
  parameter logic signed [15:0] S_NP = 16'sd0,
  parameter logic signed [15:0] S_PN = 16'sd0,
  parameter logic signed [15:0] S_PP = 16'sd1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MU_W-1:0]    muT_neg,
  input  logic [MU_W-1:0]    muT_pos,
  input  logic [MU_W-1:0]    muD_neg,
  input  logic [MU_W-1:0]    muD_pos,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] u,
  output logic               zero_w,
  output logic               busy
);

  state_e                   state_q, state_d;
  rule_e                    rule_q, rule_d;
  mu_t                      mu_q, mu_d;
  logic signed [NUM_W-1:0]  num_q, num_d;
  logic [DEN_W-1:0]         den_q, den_d;
  logic                     first_q, first_d;
  logic [15:0]              u_q, u_d;
  logic                     zero_w_q, zero_w_d;

  logic [MU_W-1:0]          mu_a, mu_b, w;
  logic signed [15:0]       s_sel;
  logic signed [NUM_W-1:0]  w_ext, s_ext, prod;
  logic                     num_neg;
  logic [MAG_W-1:0]         num_mag;
  logic                     div_start, div_done;
  logic [MAG_W-1:0]         div_quot;

  // Shared rule datapath: one min comparator and one multiplier, steered by the rule index.
  always_comb begin
    case (rule_q)
      NN:      begin mu_a = mu_q.t_neg; mu_b = mu_q.d_neg; s_sel = S_NN; end
      NP:      begin mu_a = mu_q.t_neg; mu_b = mu_q.d_pos; s_sel = S_NP; end
      PN:      begin mu_a = mu_q.t_pos; mu_b = mu_q.d_neg; s_sel = S_PN; end
      default: begin mu_a = mu_q.t_pos; mu_b = mu_q.d_pos; s_sel = S_PP; end
    endcase
    w       = (mu_a < mu_b) ? mu_a : mu_b;
    w_ext   = {{(NUM_W-MU_W){1'b0}}, w};
    s_ext   = {{(NUM_W-16){s_sel[15]}}, s_sel};
    prod    = w_ext * s_ext;
    num_neg = num_q[NUM_W-1];
    num_mag = MAG_W'(num_neg ? -num_q : num_q);
  end

  seq_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (num_mag),
    .divisor  (den_q),
    .done     (div_done),
    .quot     (div_quot)
  );

  // Sequencer: next state, accumulator updates and result capture.
  always_comb begin
    state_d   = state_q;
    rule_d    = rule_q;
    mu_d      = mu_q;
    num_d     = num_q;
    den_d     = den_q;
    first_d   = first_q;
    u_d       = u_q;
    zero_w_d  = zero_w_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mu_d    = '{t_neg: muT_neg, t_pos: muT_pos, d_neg: muD_neg, d_pos: muD_pos};
          num_d   = '0;
          den_d   = '0;
          rule_d  = NN;
          state_d = EVAL;
        end
      end
      EVAL: begin
        num_d  = num_q + prod;
        den_d  = den_q + DEN_W'(w);
        rule_d = rule_e'(rule_q + 2'd1);
        if (rule_q == PP) begin
          state_d = DIV;
          first_d = 1'b1;
        end
      end
      DIV: begin
        // First DIV cycle launches the divider; a zero weight sum waits one cycle then reports.
        first_d   = 1'b0;
        div_start = first_q && (den_q != '0);
        if (!first_q) begin
          if (den_q == '0) begin
            u_d      = '0;
            zero_w_d = 1'b1;
            state_d  = DONE;
          end else if (div_done) begin
            u_d      = sat_s16(num_neg, div_quot);
            zero_w_d = 1'b0;
            state_d  = DONE;
          end
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rule_q   <= NN;
      mu_q     <= '0;
      num_q    <= '0;
      den_q    <= '0;
      first_q  <= 1'b0;
      u_q      <= '0;
      zero_w_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rule_q   <= rule_d;
      mu_q     <= mu_d;
      num_q    <= num_d;
      den_q    <= den_d;
      first_q  <= first_d;
      u_q      <= u_d;
      zero_w_q <= zero_w_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign u         = u_q;
  assign zero_w    = zero_w_q;

endmodule

// File: tb/tb_rule_sched.sv
// Directed bench for rule_sched: scoreboard of reference results, latency, hold and reset checks.
// Two instances: default rule singletons, and all singletons at 32767.
// Runs a linear sequence of requests and prints one summary line.
module tb_rule_sched;

  typedef struct {
    logic [15:0] u;
    logic        zw;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld;
  logic        sel;
  logic        out_ready;
  logic [15:0] mu_tn, mu_tp, mu_dn, mu_dp;

  logic        in_ready_a, out_valid_a, zero_w_a, busy_a;
  logic        in_ready_b, out_valid_b, zero_w_b, busy_b;
  logic signed [15:0] u_a, u_b;

  logic        s_in_ready, s_out_valid, s_zero_w, s_busy;
  logic [15:0] s_u;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial forever #5 clk = ~clk;

  rule_sched dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(req_vld && !sel), .in_ready(in_ready_a),
    .muT_neg(mu_tn), .muT_pos(mu_tp), .muD_neg(mu_dn), .muD_pos(mu_dp),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .u(u_a), .zero_w(zero_w_a), .busy(busy_a)
  );

  rule_sched #(.S_NN(16'sd32767), .S_NP(16'sd32767), .S_PN(16'sd32767), .S_PP(16'sd32767)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(req_vld && sel), .in_ready(in_ready_b),
    .muT_neg(mu_tn), .muT_pos(mu_tp), .muD_neg(mu_dn), .muD_pos(mu_dp),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .u(u_b), .zero_w(zero_w_b), .busy(busy_b)
  );

  assign s_in_ready  = sel ? in_ready_b  : in_ready_a;
  assign s_out_valid = sel ? out_valid_b : out_valid_a;
  assign s_zero_w    = sel ? zero_w_b    : zero_w_a;
  assign s_busy      = sel ? busy_b      : busy_a;
  assign s_u         = sel ? u_b         : u_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic longint min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? longint'(a) : longint'(b);
  endfunction

  // Reference: weighted average of singletons, truncated toward zero, clamped to int16.
  function automatic exp_t model(input logic s, input logic [15:0] tn, input logic [15:0] tp,
                                 input logic [15:0] dn, input logic [15:0] dp);
    longint sv[4];
    longint wv[4];
    longint num, den, q;
    exp_t   e;
    if (s) begin
      sv[0] = 32767; sv[1] = 32767; sv[2] = 32767; sv[3] = 32767;
    end else begin
      sv[0] = -1000; sv[1] = 0; sv[2] = 0; sv[3] = 1000;
    end
    wv[0] = min16(tn, dn);
    wv[1] = min16(tn, dp);
    wv[2] = min16(tp, dn);
    wv[3] = min16(tp, dp);
    num = 0;
    den = 0;
    for (int i = 0; i < 4; i++) begin
      num += wv[i] * sv[i];
      den += wv[i];
    end
    if (den == 0) begin
      e.u = 16'h0; e.zw = 1'b1; e.lat = 6;
    end else begin
      q = ((num < 0) ? -num : num) / den;
      if (num < 0) q = -q;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      e.u = 16'(q); e.zw = 1'b0; e.lat = 39;
    end
    return e;
  endfunction

  // One full request: accept, scramble inputs, time the result, hold it, release it.
  task automatic do_req(input logic s, input logic [15:0] tn, input logic [15:0] tp,
                        input logic [15:0] dn, input logic [15:0] dp,
                        input int hold, input bit keep_valid);
    exp_t        e;
    int          lat;
    bit          rdy_bad;
    bit          stable;
    logic [15:0] u0;
    @(negedge clk);
    sel = s;
    mu_tn = tn; mu_tp = tp; mu_dn = dn; mu_dp = dp;
    req_vld = 1'b1;
    chk("in_ready_idle", 32'(s_in_ready), 32'd1);
    sb.push_back(model(s, tn, tp, dn, dp));
    @(posedge clk); #1;
    if (!keep_valid) req_vld = 1'b0;
    chk("busy_after_accept", 32'(s_busy), 32'd1);
    mu_tn = 16'($urandom); mu_tp = 16'($urandom);
    mu_dn = 16'($urandom); mu_dp = 16'($urandom);
    lat = 0;
    rdy_bad = 1'b0;
    while (s_out_valid !== 1'b1 && lat < 100) begin
      if (s_in_ready !== 1'b0) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("u", 32'(s_u), 32'(e.u));
    chk("zero_w", 32'(s_zero_w), 32'(e.zw));
    chk("in_ready_low_while_busy", 32'(rdy_bad), 32'd0);
    chk("ready_valid_exclusive", 32'(s_in_ready), 32'd0);
    u0 = s_u;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (s_out_valid !== 1'b1 || s_u !== u0 || s_in_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(s_out_valid), 32'd0);
    chk("in_ready_back", 32'(s_in_ready), 32'd1);
  endtask

  initial begin
    bit ov_seen;
    rst_n = 1'b0;
    req_vld = 1'b0;
    sel = 1'b0;
    out_ready = 1'b0;
    mu_tn = '0; mu_tp = '0; mu_dn = '0; mu_dp = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_u", 32'(u_a), 32'd0);
    chk("rst_zero_w", 32'(zero_w_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Positive and negative weighted averages, truncated toward zero.
    do_req(1'b0, 16'h4000, 16'hC000, 16'h8000, 16'h8000, 0, 1'b0);
    do_req(1'b0, 16'hC000, 16'h4000, 16'h8000, 16'h8000, 0, 1'b0);
    // All weights zero: short path.
    do_req(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);
    // Largest singletons and memberships.
    do_req(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1'b0);
    // Single active rule, and half-zero patterns.
    do_req(1'b0, 16'h0000, 16'h1234, 16'h0000, 16'hFFFF, 0, 1'b0);
    do_req(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 0, 1'b0);
    // Stalled consumer with in_valid held; the follow-up is accepted right after release.
    do_req(1'b0, 16'h4000, 16'hC000, 16'h8000, 16'h8000, 10, 1'b1);
    do_req(1'b0, 16'h7000, 16'h2000, 16'h0100, 16'hF000, 0, 1'b0);
    // A few random requests on both instances.
    for (int i = 0; i < 4; i++) begin
      do_req(1'(i & 1), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), i, 1'b0);
    end

    // Reset mid-division aborts without producing a result.
    @(negedge clk);
    sel = 1'b0;
    mu_tn = 16'h4000; mu_tp = 16'hC000; mu_dn = 16'h8000; mu_dp = 16'h8000;
    req_vld = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    chk("busy_pre_reset", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_a), 32'd1);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_u", 32'(u_a), 32'd0);
    chk("mid_rst_zero_w", 32'(zero_w_a), 32'd0);
    ov_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid_a !== 1'b0) ov_seen = 1'b1;
    end
    chk("no_out_valid_in_reset", 32'(ov_seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", 32'(in_ready_a), 32'd1);
    do_req(1'b0, 16'h4000, 16'hC000, 16'h8000, 16'h8000, 0, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
